node_agent: RTL
===============

# node_agent

Node-side endpoint of the router core's node interface. Buffers host-originated packets in a TX FIFO and presents them to the core on Packet_From_Node with a valid/ack handshake. Retries after a timeout with backoff. Captures packets delivered by the core on Packet_To_Node into an RX FIFO for the host to read. Sits between one ring router core and its local node logic.

## Interface
- DEPTH, 4, entries per FIFO (TX and RX); power of two, ≥2
- ACK_TIMEOUT, 16, cycles in PRESENT without Core_Load_Ack before backoff; ≥2
- BACKOFF_CYCLES, 4, cycles valid is held low before re-presenting; ≥1
- Clk_R  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- host_wr_en  in  1  push {host_wr_dest, host_wr_data} into TX FIFO
- host_wr_dest  in  4  destination node address
- host_wr_data  in  24  payload
- host_tx_full  out  1  TX FIFO full
- Packet_From_Node  out  29  to core: [28:25] dest, [24] reserved (0), [23:0] payload
- Packet_From_Node_Valid  out  1  to core: packet presented
- Core_Load_Ack  in  1  from core: packet accepted
- Packet_To_Node  in  24  from core: delivered payload
- Packet_To_Node_Valid  in  1  from core: one-cycle pulse, no backpressure
- host_rd_en  in  1  pop RX FIFO head
- host_rd_data  out  24  RX FIFO head (first-word fall-through)
- host_rx_empty  out  1  RX FIFO empty
- rx_overflow  out  1  sticky: delivered packet dropped because RX full
- tx_drop  out  1  sticky: host write ignored because TX full
- retry_cnt  out  8  saturating count of timeouts

## Operation
- TX FIFO: circular, log2(DEPTH)+1-bit count. A write while full is ignored and sets tx_drop, even if a pop occurs in the same cycle. Full and empty flags come from the registered count.
- Send FSM, states IDLE, PRESENT, HOLDOFF, BACKOFF. Packet_From_Node_Valid = (state==PRESENT). Packet_From_Node = TX FIFO head, held stable throughout PRESENT and BACKOFF.
- IDLE: TX non-empty -> PRESENT; wait counter cleared.
- PRESENT: Core_Load_Ack=1 -> pop TX FIFO, go to HOLDOFF. Otherwise the wait counter increments; when it reaches ACK_TIMEOUT-1 -> BACKOFF, retry_cnt+1 (saturates at 255). Ack in the timeout cycle wins: pop, no retry.
- HOLDOFF: exactly 1 cycle with valid low, so the core sees a fresh valid edge. Then -> PRESENT if TX non-empty (after pop), else IDLE.
- BACKOFF: BACKOFF_CYCLES cycles with valid low, then -> PRESENT with the same packet and the wait counter cleared.
- Core_Load_Ack outside PRESENT is ignored.
- RX FIFO: on Packet_To_Node_Valid, push Packet_To_Node if not full. If full, drop it and set rx_overflow. host_rd_en while empty is ignored. Simultaneous push and pop is legal when non-empty and non-full; count unchanged.
- Sticky flags clear only on Rst.

## Timing
- Reset (Rst=1 at a clock edge) gives, next cycle:
  - state IDLE, Packet_From_Node_Valid=0, Packet_From_Node=0
  - both FIFOs empty: host_tx_full=0, host_rx_empty=1, host_rd_data=0
  - rx_overflow=0, tx_drop=0, retry_cnt=0, wait counter 0
- Reset mid-PRESENT discards the in-flight packet and all queued data.
- Write to empty TX FIFO at edge t: FIFO non-empty after t, FSM enters PRESENT at t+1, valid high in cycle after t+1 (2-cycle latency).
- Ack sampled at edge k: valid low from k (HOLDOFF), high again from k+1 if more data. Back-to-back packets therefore occupy ≥2 cycles each.
- No ack: valid high for ACK_TIMEOUT cycles, low for BACKOFF_CYCLES, then high again.
- RX: Packet_To_Node_Valid at edge t -> host_rx_empty=0 and host_rd_data valid after t (1-cycle latency).
- All outputs registered or decoded from registered state only; no combinational input-to-output path.

## Test plan
- Reset then single write (dest=4'h5, data=24'hABCDEF): Packet_From_Node=29'h0AABCDEF with valid 2 cycles later; ack on 3rd valid cycle -> valid low next cycle, TX empty, FSM IDLE.
- Fill TX with 4 packets, 5th write -> tx_drop=1, host_tx_full=1. Ack each immediately -> packets presented in order with valid pattern 1,0,1,0…
- No ack, defaults: valid high 16 cycles, low 4, high again with identical data, retry_cnt=1. Ack asserted in the 16th cycle -> no backoff, retry_cnt stays 0.
- Deliver 5 pulses on Packet_To_Node (24'h000001..24'h000005) with no reads -> reads return 1..4, rx_overflow=1, host_rx_empty=1 after 4 pops.
- Simultaneous RX push (24'h00C0DE) and pop with 2 entries -> count stays 2, FIFO order preserved. Pop on empty has no effect.
- Assert Rst while PRESENT with 3 queued packets -> next cycle valid=0, TX empty, retry_cnt=0, sticky flags cleared.

Source files
------------

// File: rtl/node_agent_if.sv
// Host- and core-facing signal bundle of the node agent.
// slave = the agent itself, master = whatever drives it (host logic + core).
interface node_agent_if;
  // host write side (TX)
  logic        host_wr_en;
  logic [3:0]  host_wr_dest;
  logic [23:0] host_wr_data;
  logic        host_tx_full;
  // core send side
  logic [28:0] Packet_From_Node;
  logic        Packet_From_Node_Valid;
  logic        Core_Load_Ack;
  // core delivery side
  logic [23:0] Packet_To_Node;
  logic        Packet_To_Node_Valid;
  // host read side (RX)
  logic        host_rd_en;
  logic [23:0] host_rd_data;
  logic        host_rx_empty;
  // status
  logic        rx_overflow;
  logic        tx_drop;
  logic [7:0]  retry_cnt;

  modport slave (
    input  host_wr_en, host_wr_dest, host_wr_data, Core_Load_Ack,
           Packet_To_Node, Packet_To_Node_Valid, host_rd_en,
    output host_tx_full, Packet_From_Node, Packet_From_Node_Valid,
           host_rd_data, host_rx_empty, rx_overflow, tx_drop, retry_cnt
  );

  modport master (
    output host_wr_en, host_wr_dest, host_wr_data, Core_Load_Ack,
           Packet_To_Node, Packet_To_Node_Valid, host_rd_en,
    input  host_tx_full, Packet_From_Node, Packet_From_Node_Valid,
           host_rd_data, host_rx_empty, rx_overflow, tx_drop, retry_cnt
  );
endinterface

// File: rtl/node_agent.sv
// Node-side endpoint of a ring router core: TX FIFO + send FSM with
// ack timeout / backoff retry, and an RX FIFO capturing delivered payloads.
module node_agent #(
  parameter int DEPTH          = 4,
  parameter int ACK_TIMEOUT    = 16,
  parameter int BACKOFF_CYCLES = 4
) (
  input  logic         Clk_R,
  input  logic         Rst,
  node_agent_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(ACK_TIMEOUT);
  localparam int BW = $clog2(BACKOFF_CYCLES + 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] TO_LAST  = WW'(ACK_TIMEOUT - 1);
  localparam logic [BW-1:0] BO_LAST  = BW'(BACKOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLDOFF, BACKOFF} state_t;

  // ---------------- TX FIFO ----------------
  logic [27:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [27:0]   tx_head;

  assign tx_full  = (tx_cnt == CNT_FULL);
  assign tx_empty = (tx_cnt == '0);
  // full is judged on the registered count, so a same-cycle pop never frees room
  assign tx_push  = bus.host_wr_en && !tx_full;
  assign tx_head  = tx_mem[tx_rp];

  // TX storage write; contents need no reset since the count gates visibility
  always_ff @(posedge Clk_R) begin
    if (tx_push) tx_mem[tx_wp] <= {bus.host_wr_dest, bus.host_wr_data};
  end

  // TX pointers, occupancy and the dropped-write flag
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      tx_wp   <= '0;
      tx_rp   <= '0;
      tx_cnt  <= '0;
      bus.tx_drop <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (AW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (AW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (bus.host_wr_en && tx_full) bus.tx_drop <= 1'b1;
    end
  end

  // ---------------- Send FSM ----------------
  state_t        state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [BW-1:0] boff_cnt, boff_n;
  logic          retry_hit;

  // state and counter registers
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      boff_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      boff_cnt <= boff_n;
    end
  end

  // next state, FIFO pop and timeout detection
  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    boff_n    = boff_cnt;
    tx_pop    = 1'b0;
    retry_hit = 1'b0;
    case (state)
      IDLE: begin
        wait_n = '0;
        if (!tx_empty) state_n = PRESENT;
      end
      PRESENT: begin
        if (bus.Core_Load_Ack) begin
          // ack wins even in the timeout cycle
          tx_pop  = 1'b1;
          wait_n  = '0;
          state_n = HOLDOFF;
        end else if (wait_cnt == TO_LAST) begin
          retry_hit = 1'b1;
          wait_n    = '0;
          boff_n    = '0;
          state_n   = BACKOFF;
        end else begin
          wait_n = wait_cnt + WW'(1);
        end
      end
      HOLDOFF: begin
        // one low cycle so the core sees a fresh valid edge
        wait_n  = '0;
        state_n = tx_empty ? IDLE : PRESENT;
      end
      BACKOFF: begin
        if (boff_cnt == BO_LAST) begin
          wait_n  = '0;
          state_n = PRESENT;
        end else begin
          boff_n = boff_cnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // saturating timeout counter
  always_ff @(posedge Clk_R) begin
    if (Rst)                                 bus.retry_cnt <= '0;
    else if (retry_hit && bus.retry_cnt != 8'hFF) bus.retry_cnt <= bus.retry_cnt + 8'd1;
  end

  assign bus.Packet_From_Node_Valid = (state == PRESENT);
  // head is stable while non-empty: writes never target the read slot
  assign bus.Packet_From_Node = tx_empty ? '0 : {tx_head[27:24], 1'b0, tx_head[23:0]};
  assign bus.host_tx_full     = tx_full;

  // ---------------- RX FIFO ----------------
  logic [23:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  assign rx_full  = (rx_cnt == CNT_FULL);
  assign rx_empty = (rx_cnt == '0);
  assign rx_push  = bus.Packet_To_Node_Valid && !rx_full;
  assign rx_pop   = bus.host_rd_en && !rx_empty;

  // RX storage write
  always_ff @(posedge Clk_R) begin
    if (rx_push) rx_mem[rx_wp] <= bus.Packet_To_Node;
  end

  // RX pointers, occupancy and the overflow flag
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      bus.rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (AW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (AW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (bus.Packet_To_Node_Valid && rx_full) bus.rx_overflow <= 1'b1;
    end
  end

  assign bus.host_rx_empty = rx_empty;
  assign bus.host_rd_data  = rx_empty ? '0 : rx_mem[rx_rp];

endmodule
